// File: rtl/adder_sweep_checker_if.sv
// Adder bus between the sweep checker and the combinational adder under test.
//   master (checker): drives a, b, cin; receives dut_out, dut_cout
//   slave  (adder)  : receives a, b, cin; drives dut_out, dut_cout
interface adder_sweep_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] dut_out;
  logic             dut_cout;

  modport master (output a, b, cin, input dut_out, dut_cout);
  modport slave  (input a, b, cin, output dut_out, dut_cout);
endinterface

// File: rtl/adder_sweep_checker.sv
// Self-test engine for a WIDTH-bit ripple adder. On start it sweeps every
// operand combination (cin outer, a middle, b inner), holds each vector for
// SETTLE cycles, then compares the adder result with a golden sum.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a sweep (honoured only when idle or done)
//   bus                 adder bus (master side): a, b, cin out; dut_out, dut_cout in
//   busy, done, pass    sweep running / sweep finished / finished with no errors
//   err_count           saturating count of mismatching vectors
//   fail_valid, fail_a, fail_b, fail_cin   first failing vector of the sweep
module adder_sweep_checker #(
  parameter int WIDTH     = 8,
  parameter int SWEEP_MAX = 128,
  parameter int SETTLE    = 1,
  parameter int ERR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  adder_sweep_checker_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  fail_valid,
  output logic [WIDTH-1:0]      fail_a,
  output logic [WIDTH-1:0]      fail_b,
  output logic                  fail_cin
);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  localparam int               CNT_W     = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WIDTH-1:0] LAST      = WIDTH'(SWEEP_MAX - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
  // With no settle time each vector is checked on the cycle it is driven.
  localparam state_t           FIRST     = (SETTLE == 0) ? CHECK : WAIT;

  state_t           state, state_next;
  logic             start_q;
  logic [WIDTH-1:0] op_a, op_a_next;
  logic [WIDTH-1:0] op_b, op_b_next;
  logic             op_cin, op_cin_next;
  logic [CNT_W-1:0] settle, settle_next;
  logic [ERR_W-1:0] err_next;
  logic             fail_valid_next;
  logic [WIDTH-1:0] fail_a_next, fail_b_next;
  logic             fail_cin_next;
  logic             pass_next;
  logic [WIDTH:0]   expected;
  logic             mismatch;
  logic             last_vec;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign bus.a   = op_a;
  assign bus.b   = op_b;
  assign bus.cin = op_cin;
  assign busy    = (state == WAIT) || (state == CHECK);
  assign done    = (state == DONE);

  assign expected = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
  assign mismatch = ({bus.dut_cout, bus.dut_out} != expected);

  always_comb begin
    state_next      = state;
    op_a_next       = op_a;
    op_b_next       = op_b;
    op_cin_next     = op_cin;
    settle_next     = settle;
    err_next        = err_count;
    fail_valid_next = fail_valid;
    fail_a_next     = fail_a;
    fail_b_next     = fail_b;
    fail_cin_next   = fail_cin;
    pass_next       = pass;
    last_vec        = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start_q) begin
          state_next      = FIRST;
          op_a_next       = '0;
          op_b_next       = '0;
          op_cin_next     = 1'b0;
          settle_next     = SETTLE_LD;
          err_next        = '0;
          fail_valid_next = 1'b0;
          fail_a_next     = '0;
          fail_b_next     = '0;
          fail_cin_next   = 1'b0;
          pass_next       = 1'b0;
        end
      end

      WAIT: begin
        settle_next = settle - CNT_W'(1);
        if (settle == CNT_W'(1)) state_next = CHECK;
      end

      CHECK: begin
        if (mismatch) begin
          err_next = sat_inc(err_count);
          if (!fail_valid) begin
            fail_valid_next = 1'b1;
            fail_a_next     = op_a;
            fail_b_next     = op_b;
            fail_cin_next   = op_cin;
          end
        end

        // Odometer advance: b fastest, then a, then cin.
        if (op_b != LAST) begin
          op_b_next = op_b + WIDTH'(1);
        end else begin
          op_b_next = '0;
          if (op_a != LAST) begin
            op_a_next = op_a + WIDTH'(1);
          end else begin
            op_a_next = '0;
            if (!op_cin) op_cin_next = 1'b1;
            else         last_vec    = 1'b1;
          end
        end

        if (last_vec) begin
          state_next  = DONE;
          op_cin_next = 1'b0;
          // Includes the verdict of the vector checked on this very cycle.
          pass_next   = (err_next == '0);
        end else begin
          settle_next = SETTLE_LD;
          state_next  = FIRST;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      settle     <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_cin   <= 1'b0;
      pass       <= 1'b0;
    end else begin
      // Input stage: start is registered, and masked while a sweep runs.
      start_q    <= start && ((state == IDLE) || (state == DONE));
      // Sweep stage.
      state      <= state_next;
      op_a       <= op_a_next;
      op_b       <= op_b_next;
      op_cin     <= op_cin_next;
      settle     <= settle_next;
      err_count  <= err_next;
      fail_valid <= fail_valid_next;
      fail_a     <= fail_a_next;
      fail_b     <= fail_b_next;
      fail_cin   <= fail_cin_next;
      pass       <= pass_next;
    end
  end

endmodule

// File: tb/tb_adder_sweep_checker.sv
`timescale 1ns/1ps
module tb_adder_sweep_checker;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  // u0: SWEEP_MAX=4, SETTLE=1, adder with a programmable per-vector fault table
  localparam int SM0 = 4;
  localparam int S0  = 1;
  localparam int NV0 = 2 * SM0 * SM0;
  adder_sweep_checker_if #(.WIDTH(W)) bus0 ();
  logic            start0, busy0, done0, pass0, fv0, fcin0;
  logic [15:0]     err0;
  logic [W-1:0]    fa0, fb0;
  logic [W:0]      fault0 [NV0];
  logic [W:0]      sum0;
  logic [4:0]      idx0;
  assign sum0 = {1'b0, bus0.a} + {1'b0, bus0.b} + {{W{1'b0}}, bus0.cin};
  assign idx0 = {bus0.cin, bus0.a[1:0], bus0.b[1:0]};
  assign {bus0.dut_cout, bus0.dut_out} = sum0 ^ fault0[idx0];

  adder_sweep_checker #(.WIDTH(W), .SWEEP_MAX(SM0), .SETTLE(S0), .ERR_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0), .fail_cin(fcin0));

  // u1: defaults, adder sum bit 0 stuck at 0
  adder_sweep_checker_if #(.WIDTH(W)) bus1 ();
  logic            start1, busy1, done1, pass1, fv1, fcin1;
  logic [15:0]     err1;
  logic [W-1:0]    fa1, fb1;
  logic [W:0]      sum1;
  assign sum1 = {1'b0, bus1.a} + {1'b0, bus1.b} + {{W{1'b0}}, bus1.cin};
  assign {bus1.dut_cout, bus1.dut_out} = {sum1[W:1], 1'b0};

  adder_sweep_checker u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_cin(fcin1));

  // u2: ERR_W=4, SWEEP_MAX=3, SETTLE=0, adder output inverted (18 failures saturate)
  localparam int SM2 = 3;
  adder_sweep_checker_if #(.WIDTH(W)) bus2 ();
  logic            start2, busy2, done2, pass2, fv2, fcin2;
  logic [3:0]      err2;
  logic [W-1:0]    fa2, fb2;
  logic [W:0]      sum2;
  assign sum2 = {1'b0, bus2.a} + {1'b0, bus2.b} + {{W{1'b0}}, bus2.cin};
  assign {bus2.dut_cout, bus2.dut_out} = ~sum2;

  adder_sweep_checker #(.WIDTH(W), .SWEEP_MAX(SM2), .SETTLE(0), .ERR_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2), .fail_cin(fcin2));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full u0 sweep from start to done, against a model built from the fault table.
  task automatic run_u0(input string tag, input bit poke);
    int exp_err, first, id, j, done_at, bad_order, bad_busy;
    logic [16:0] exp_vec;
    exp_err = 0;
    first   = -1;
    for (int c = 0; c < 2; c++)
      for (int x = 0; x < SM0; x++)
        for (int y = 0; y < SM0; y++) begin
          id = c * SM0 * SM0 + x * SM0 + y;
          if (fault0[id] != '0) begin
            exp_err++;
            if (first < 0) first = id;
          end
        end

    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;  // edge k is behind us
    done_at   = -1;
    bad_order = 0;
    bad_busy  = 0;
    for (int m = 1; m <= 200; m++) begin
      @(negedge clk);
      start0 = poke && (m == 10 || m == 11);
      if (m == 1) check({tag, " cleared"}, {done0, pass0, fv0, err0}, '0);
      if (done0) begin
        done_at = m;
        break;
      end
      if (!busy0) bad_busy++;
      j = (m - 1) / (S0 + 1);
      exp_vec = {1'(j / (SM0 * SM0)), 8'((j / SM0) % SM0), 8'(j % SM0)};
      if ({bus0.cin, bus0.a, bus0.b} !== exp_vec) bad_order++;
    end
    start0 = 1'b0;

    check({tag, " done_cycle"}, done_at, 1 + NV0 * (S0 + 1));
    check({tag, " order"}, bad_order, 0);
    check({tag, " busy"}, bad_busy, 0);
    check({tag, " err_count"}, err0, exp_err);
    check({tag, " pass"}, pass0, exp_err == 0);
    check({tag, " fail_valid"}, fv0, first >= 0);
    if (first >= 0) exp_vec = {1'(first / (SM0 * SM0)), 8'((first / SM0) % SM0), 8'(first % SM0)};
    else            exp_vec = '0;
    check({tag, " fail_vec"}, {fcin0, fa0, fb0}, exp_vec);
    check({tag, " done_state"}, {done0, busy0, bus0.cin, bus0.a, bus0.b}, {1'b1, 18'd0});
  endtask

  initial begin
    int done_at, bad, exp_err, first;
    logic [16:0] exp_vec;

    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int i = 0; i < NV0; i++) fault0[i] = '0;

    // Reset and idle
    repeat (2) @(negedge clk);
    check("u0 reset", {busy0, done0, pass0, err0, fv0, fa0, fb0, fcin0, bus0.a, bus0.b, bus0.cin}, '0);
    check("u1 reset", {busy1, done1, pass1, err1, fv1, fa1, fb1, fcin1, bus1.a, bus1.b, bus1.cin}, '0);
    check("u2 reset", {busy2, done2, pass2, err2, fv2, fa2, fb2, fcin2, bus2.a, bus2.b, bus2.cin}, '0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if ({busy0, done0, pass0, err0, fv0, fa0, fb0, fcin0, bus0.a, bus0.b, bus0.cin} !== '0) bad++;
    end
    check("u0 idle 20 cycles", bad, 0);

    // Ideal adder
    run_u0("u0 ideal", 1'b0);

    // Random faults, started from DONE
    for (int i = 0; i < NV0; i++)
      fault0[i] = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(1, 511)) : '0;
    fault0[$urandom_range(0, NV0 - 1)] = 9'($urandom_range(1, 511));
    run_u0("u0 random", 1'b0);

    // Fresh random faults, start pulsed in WAIT and CHECK
    for (int i = 0; i < NV0; i++)
      fault0[i] = ($urandom_range(0, 2) == 0) ? 9'($urandom_range(1, 511)) : '0;
    fault0[$urandom_range(0, NV0 - 1)] = 9'($urandom_range(1, 511));
    run_u0("u0 poke", 1'b1);

    // Inverted adder, SETTLE=0, saturating 4-bit counter
    exp_err = 0;
    for (int c = 0; c < 2; c++)
      for (int x = 0; x < SM2; x++)
        for (int y = 0; y < SM2; y++) exp_err++;
    if (exp_err > 15) exp_err = 15;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    done_at = -1;
    for (int m = 1; m <= 100; m++) begin
      @(negedge clk);
      if (done2) begin
        done_at = m;
        break;
      end
    end
    check("u2 done_cycle", done_at, 1 + 2 * SM2 * SM2);
    check("u2 err_count", err2, exp_err);
    check("u2 pass", pass2, 1'b0);
    check("u2 fail", {fv2, fcin2, fa2, fb2}, {1'b1, 17'd0});

    // Asynchronous reset in the middle of vector 100
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (1 + 100 * 2) @(negedge clk);
    check("u1 vector 100", {bus1.cin, bus1.a, bus1.b}, {1'b0, 8'd0, 8'd100});
    #2 rst_n = 1'b0;
    #1;
    check("u1 async reset", {busy1, done1, pass1, err1, fv1, fa1, fb1, fcin1, bus1.a, bus1.b, bus1.cin}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (done1 || busy1) bad++;
    end
    check("u1 no done after reset", bad, 0);

    for (int i = 0; i < NV0; i++) fault0[i] = '0;
    run_u0("u0 after reset", 1'b0);

    // Defaults, sum bit 0 stuck at 0: fails whenever a+b+cin is odd
    exp_err = 0;
    first   = -1;
    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 128; x++)
        for (int y = 0; y < 128; y++)
          if (((x + y + c) % 2) == 1) begin
            exp_err++;
            if (first < 0) first = c * 16384 + x * 128 + y;
          end
    exp_vec = {1'(first / 16384), 8'((first / 128) % 128), 8'(first % 128)};
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    done_at = -1;
    for (int m = 1; m <= 70000; m++) begin
      @(negedge clk);
      if (done1) begin
        done_at = m;
        break;
      end
    end
    check("u1 done_cycle", done_at, 1 + 2 * 128 * 128 * 2);
    check("u1 err_count", err1, exp_err);
    check("u1 fail_valid", fv1, 1'b1);
    check("u1 fail_vec", {fcin1, fa1, fb1}, exp_vec);
    check("u1 pass", pass1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
